// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-back data cache.
//   state_e     : controller states
//   line_meta_t : per-line bookkeeping view (valid, dirty, tag)
//   off_w/idx_w/tag_w : address-field widths derived from cache geometry
package dcache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_REFILL,
    ST_RESPOND
  } state_e;

  // Tags are carried in a fixed-width field and zero-extended on compare.
  localparam int unsigned TAG_MAX_W = 32;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } line_meta_t;

  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned lines,
                                        input int unsigned words);
    return addr_w - idx_w(lines) - off_w(words) - 2;
  endfunction

  // Storage width for a field that may legitimately be zero bits wide.
  function automatic int unsigned nonzero_w(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Cache data array: LINES*WORDS_PER_LINE words of DATA_W bits.
// Synchronous write, combinational read; shared by hit, writeback and refill.
//   clk     : clock
//   we_i    : write enable
//   idx_i   : line index (read and write share the line)
//   woff_i  : write word offset
//   wdata_i : write data
//   roff_i  : read word offset
//   rdata_o : read data (combinational)
module dcache_data_ram
  import dcache_pkg::*;
#(
  parameter int unsigned LINES          = 256,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned DATA_W         = 32
) (
  input  logic                                clk,
  input  logic                                we_i,
  input  logic [idx_w(LINES)-1:0]             idx_i,
  input  logic [nonzero_w(off_w(WORDS_PER_LINE))-1:0] woff_i,
  input  logic [DATA_W-1:0]                   wdata_i,
  input  logic [nonzero_w(off_w(WORDS_PER_LINE))-1:0] roff_i,
  output logic [DATA_W-1:0]                   rdata_o
);

  localparam int unsigned DEPTH = LINES * WORDS_PER_LINE;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     raddr;

  assign waddr = AW'(idx_i) * AW'(WORDS_PER_LINE) + AW'(woff_i);
  assign raddr = AW'(idx_i) * AW'(WORDS_PER_LINE) + AW'(roff_i);

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr];

endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache with multi-word lines.
//   clk, reset          : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata : core request, held until cpu_ready
//   cpu_rdata/cpu_ready : load data and one-cycle completion pulse
//   mem_req/we/addr/wdata, mem_rdata, mem_ack : word-beat memory handshake
//   hit_count/miss_count : completed hit/miss accesses (wrapping)
module dcache_wb_dm
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LINES          = 256,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned CNT_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned OFF_W   = off_w(WORDS_PER_LINE);
  localparam int unsigned IDX_W   = idx_w(LINES);
  localparam int unsigned TAG_W   = tag_w(ADDR_W, LINES, WORDS_PER_LINE);
  localparam int unsigned OFF_SW  = nonzero_w(OFF_W);
  localparam int unsigned LSB_IDX = OFF_W + 2;
  localparam int unsigned LSB_TAG = IDX_W + OFF_W + 2;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q;
  logic                req_we_q;
  logic [DATA_W-1:0]   req_wdata_q;
  logic [OFF_SW-1:0]   beat_q, beat_d;
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;
  logic [TAG_W-1:0]    tag_q [LINES];
  logic [DATA_W-1:0]   cpu_rdata_q, rdata_d;
  logic [CNT_W-1:0]    hit_q, miss_q;

  logic [IDX_W-1:0]    req_idx;
  logic [OFF_SW-1:0]   req_off;
  logic [TAG_W-1:0]    req_tag;
  line_meta_t          meta;
  logic                hit;
  logic                last_beat;

  logic                ram_we;
  logic [OFF_SW-1:0]   ram_woff;
  logic [DATA_W-1:0]   ram_wdata;
  logic [OFF_SW-1:0]   ram_roff;
  logic [DATA_W-1:0]   ram_rdata;

  logic                hit_inc, miss_inc;
  logic                set_dirty, clr_dirty, clr_valid, fill_done;

  // Field extraction by shifting keeps WORDS_PER_LINE=1 (zero-width offset) legal.
  assign req_idx = IDX_W'(req_addr_q >> LSB_IDX);
  assign req_off = OFF_SW'(req_addr_q >> 2) & OFF_SW'(WORDS_PER_LINE - 1);
  assign req_tag = TAG_W'(req_addr_q >> LSB_TAG);

  assign meta = '{valid: valid_q[req_idx],
                  dirty: dirty_q[req_idx],
                  tag:   TAG_MAX_W'(tag_q[req_idx])};
  assign hit       = meta.valid && (meta.tag == TAG_MAX_W'(req_tag));
  assign last_beat = (beat_q == OFF_SW'(WORDS_PER_LINE - 1));

  dcache_data_ram #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .DATA_W         (DATA_W)
  ) u_data (
    .clk     (clk),
    .we_i    (ram_we),
    .idx_i   (req_idx),
    .woff_i  (ram_woff),
    .wdata_i (ram_wdata),
    .roff_i  (ram_roff),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    ram_we    = 1'b0;
    ram_woff  = req_off;
    ram_wdata = req_wdata_q;
    ram_roff  = req_off;
    rdata_d   = cpu_rdata_q;
    cpu_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    clr_valid = 1'b0;
    fill_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) state_d = ST_LOOKUP;
      end

      ST_LOOKUP: begin
        if (hit) begin
          cpu_ready = 1'b1;
          hit_inc   = 1'b1;
          state_d   = ST_IDLE;
          if (req_we_q) begin
            ram_we    = 1'b1;
            set_dirty = 1'b1;
          end else begin
            rdata_d = ram_rdata;
          end
        end else begin
          // The line is invalidated up front so an abandoned refill never
          // leaves a half-filled line looking resident.
          clr_valid = 1'b1;
          beat_d    = '0;
          state_d   = (meta.valid && meta.dirty) ? ST_WRITEBACK : ST_REFILL;
        end
      end

      ST_WRITEBACK: begin
        ram_roff  = beat_q;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = (ADDR_W'(tag_q[req_idx]) << LSB_TAG) |
                    (ADDR_W'(req_idx) << LSB_IDX) | (ADDR_W'(beat_q) << 2);
        mem_wdata = ram_rdata;
        if (mem_ack) begin
          if (last_beat) begin
            clr_dirty = 1'b1;
            beat_d    = '0;
            state_d   = ST_REFILL;
          end else begin
            beat_d = beat_q + OFF_SW'(1);
          end
        end
      end

      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = (ADDR_W'(req_tag) << LSB_TAG) |
                   (ADDR_W'(req_idx) << LSB_IDX) | (ADDR_W'(beat_q) << 2);
        if (mem_ack) begin
          ram_we    = 1'b1;
          ram_woff  = beat_q;
          ram_wdata = mem_rdata;
          if (last_beat) begin
            fill_done = 1'b1;
            state_d   = ST_RESPOND;
          end else begin
            beat_d = beat_q + OFF_SW'(1);
          end
        end
      end

      ST_RESPOND: begin
        cpu_ready = 1'b1;
        miss_inc  = 1'b1;
        state_d   = ST_IDLE;
        if (req_we_q) begin
          ram_we    = 1'b1;
          set_dirty = 1'b1;
        end else begin
          rdata_d = ram_rdata;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_rdata  = rdata_d;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      beat_q      <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      cpu_rdata_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cpu_rdata_q <= rdata_d;
      if (state_q == ST_IDLE && cpu_req) begin
        req_addr_q  <= cpu_addr;
        req_we_q    <= cpu_we;
        req_wdata_q <= cpu_wdata;
      end
      if (clr_valid) valid_q[req_idx] <= 1'b0;
      if (clr_dirty) dirty_q[req_idx] <= 1'b0;
      if (fill_done) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (set_dirty) dirty_q[req_idx] <= 1'b1;
      if (hit_inc)   hit_q  <= hit_q + CNT_W'(1);
      if (miss_inc)  miss_q <= miss_q + CNT_W'(1);
    end
  end

  // Tags are not reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_dcache_wb_dm.sv
module tb_dcache_wb_dm;

  localparam int unsigned LIMIT = 400;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  dcache_wb_dm #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .LINES          (256),
    .WORDS_PER_LINE (4),
    .CNT_W          (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t log_q[$];
  beat_t exp_q[$];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Main memory seen by the DUT.
  logic [31:0] mem_arr [logic [31:0]];
  int unsigned wait_cnt = 0;
  logic        hold_ack = 1'b0;

  // Reference model: cache contents and a separate image of memory.
  bit          m_valid [256];
  bit          m_dirty [256];
  logic [19:0] m_tag   [256];
  logic [31:0] m_data  [1024];
  logic [31:0] mm      [logic [31:0]];
  int unsigned m_hits   = 0;
  int unsigned m_misses = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  function automatic logic [31:0] arr_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : dflt(a);
  endfunction

  function automatic logic [31:0] mm_rd(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : dflt(a);
  endfunction

  // Memory responder: three stall cycles, acknowledge in the fourth.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!reset || !mem_req || hold_ack) begin
      wait_cnt = 0;
    end else if (wait_cnt == 3) begin
      wait_cnt = 0;
      mem_ack  = 1'b1;
      if (mem_we) begin
        mem_arr[mem_addr] = mem_wdata;
        log_q.push_back('{we: 1'b1, addr: mem_addr, data: mem_wdata});
      end else begin
        mem_rdata = arr_rd(mem_addr);
        log_q.push_back('{we: 1'b0, addr: mem_addr, data: mem_rdata});
      end
    end else begin
      wait_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata,
                              output logic [31:0] rd, output bit was_hit);
    int unsigned idx = (addr >> 4) & 255;
    int unsigned off = (addr >> 2) & 3;
    logic [19:0] tag = 20'(addr >> 12);
    logic [31:0] a;
    exp_q.delete();
    was_hit = m_valid[idx] && (m_tag[idx] == tag);
    if (!was_hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int w = 0; w < 4; w++) begin
          a = (32'(m_tag[idx]) << 12) | (32'(idx) << 4) | (32'(w) << 2);
          exp_q.push_back('{we: 1'b1, addr: a, data: m_data[idx*4 + w]});
          mm[a] = m_data[idx*4 + w];
        end
      end
      for (int w = 0; w < 4; w++) begin
        a = (32'(tag) << 12) | (32'(idx) << 4) | (32'(w) << 2);
        m_data[idx*4 + w] = mm_rd(a);
        exp_q.push_back('{we: 1'b0, addr: a, data: m_data[idx*4 + w]});
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      m_misses++;
    end else begin
      m_hits++;
    end
    if (we) begin
      m_data[idx*4 + off] = wdata;
      m_dirty[idx] = 1'b1;
    end
    rd = m_data[idx*4 + off];
  endtask

  task automatic chk_beats(input string tag);
    chk({tag, "_nbeats"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({tag, "_beat_we"},   32'(log_q[i].we), 32'(exp_q[i].we));
      chk({tag, "_beat_addr"}, log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) chk({tag, "_beat_wdata"}, log_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic start_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata);
    log_q.delete();
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  // Waits for cpu_ready, then checks data, latency, counters and memory traffic.
  task automatic finish_access(input string tag, input logic we,
                               input logic [31:0] exp_rd, input bit exp_hit,
                               output logic [31:0] got_rd);
    int unsigned lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ready && lat < LIMIT);
    chk({tag, "_timeout"}, 32'(lat >= LIMIT), 32'd0);
    got_rd  = cpu_rdata;
    cpu_req = 1'b0;
    if (!we) chk({tag, "_rdata"}, cpu_rdata, exp_rd);
    if (exp_hit) chk({tag, "_hit_latency"}, 32'(lat), 32'd1);
    @(negedge clk);
    chk({tag, "_ready_pulse"}, 32'(cpu_ready), 32'd0);
    chk({tag, "_hit_count"},  hit_count,  m_hits);
    chk({tag, "_miss_count"}, miss_count, m_misses);
    chk_beats(tag);
  endtask

  task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] got_rd);
    logic [31:0] exp_rd;
    bit          exp_hit;
    model_access(we, addr, wdata, exp_rd, exp_hit);
    start_access(we, addr, wdata);
    finish_access(tag, we, exp_rd, exp_hit, got_rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_rd;
    bit          exp_hit;
    int unsigned n;
    int unsigned pulses;

    reset     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req",   32'(mem_req), 32'd0);
    chk("rst_mem_we",    32'(mem_we), 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_hits",      hit_count, 32'd0);
    chk("rst_misses",    miss_count, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed scenarios.
    do_access("cold_load", 1'b0, 32'h0000_0010, 32'h0, rd);
    chk("cold_load_value", rd, 32'hA5A5A5B5);
    do_access("hit_load", 1'b0, 32'h0000_0014, 32'h0, rd);
    chk("hit_load_value", rd, 32'hA5A5A5B1);
    do_access("hit_store", 1'b1, 32'h0000_0018, 32'hDEADBEEF, rd);
    do_access("conflict_load", 1'b0, 32'h0000_1010, 32'h0, rd);
    chk("conflict_load_value", rd, 32'hA5A5B5B5);
    do_access("store_miss", 1'b1, 32'h0000_2004, 32'h12345678, rd);
    do_access("load_after_store", 1'b0, 32'h0000_2004, 32'h0, rd);
    chk("load_after_store_value", rd, 32'h12345678);

    // Long memory stall in the middle of a writeback of the dirty 0x2000 line.
    model_access(1'b0, 32'h0000_3008, 32'h0, exp_rd, exp_hit);
    start_access(1'b0, 32'h0000_3008, 32'h0);
    n = 0;
    while (log_q.size() < 2 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_timeout", 32'(n >= LIMIT), 32'd0);
    @(posedge clk);
    #1 hold_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_mem_req",   32'(mem_req), 32'd1);
      chk("stall_mem_we",    32'(mem_we), 32'd1);
      chk("stall_mem_addr",  mem_addr, exp_q[2].addr);
      chk("stall_mem_wdata", mem_wdata, exp_q[2].data);
      chk("stall_cpu_ready", 32'(cpu_ready), 32'd0);
      cpu_req  = i[0];
      cpu_we   = 1'($urandom_range(0, 1));
      cpu_addr = $urandom & 32'hFFFF_FFFC;
    end
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0000_3008;
    hold_ack  = 1'b0;
    finish_access("stall", 1'b0, exp_rd, exp_hit, rd);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ready) pulses++;
    end
    chk("stall_extra_pulses", 32'(pulses), 32'd0);

    // Reset in the middle of a refill.
    start_access(1'b0, 32'h0000_5040, 32'h0);
    n = 0;
    while (log_q.size() < 2 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_reach_timeout", 32'(n >= LIMIT), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rstmid_mem_req",   32'(mem_req), 32'd0);
    chk("rstmid_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rstmid_hits",      hit_count, 32'd0);
    chk("rstmid_misses",    miss_count, 32'd0);
    cpu_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_access("after_reset", 1'b0, 32'h0000_5040, 32'h0, rd);
    chk("after_reset_value", rd, 32'hA5A5F5E5);
    chk("after_reset_misses", miss_count, 32'd1);

    // Randomised accesses over a few conflicting tags and indices.
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic        w;
      a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      w = 1'($urandom_range(0, 1));
      do_access("rand", w, a, $urandom, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
